led_switch_ctrl: RTL and testbench

- Mode controller for the board's two-LED / two-switch datapath.
- Synchronises and debounces the two slide switches and a mode push-button.
- A 4-state mode FSM selects what drives the LEDs: the existing direct switch function, a gated blink, a two-LED chase, or off.
- Sits between the raw board pins and the LED pins; all outputs are registered.

---
 rtl/led_switch_ctrl_pkg.sv | 20 ++
 rtl/led_switch_ctrl_if.sv | 10 +
 rtl/led_switch_ctrl_sw_debounce.sv | 53 +++++
 rtl/led_switch_ctrl.sv | 93 +++++++++
 tb/tb_led_switch_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/led_switch_ctrl_pkg.sv
// Shared types and sizing helpers for the LED/switch mode controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  // Counter holding 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    return mode_e'(m + 2'd1);
  endfunction

endpackage

// File: rtl/led_switch_ctrl_if.sv
// Board-side pin bundle: raw switches/button in, LED drive and mode out.
interface led_switch_ctrl_if;
  logic [1:0] switch;
  logic       mode_btn;
  logic [1:0] led;
  logic [1:0] mode;

  modport master (output switch, output mode_btn, input led, input mode);
  modport slave  (input switch, input mode_btn, output led, output mode);
endinterface

// File: rtl/led_switch_ctrl_sw_debounce.sv
// Two-flop synchroniser followed by a persistence-count debouncer for one input.
module sw_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int             CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any bounce back to the stable level throws away accumulated progress.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/led_switch_ctrl.sv
// Mode controller: debounced inputs, button-driven 4-state mode FSM,
// blink/chase prescaler and registered LED drive.
module led_switch_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_HALF      = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  led_switch_ctrl_if.slave bus
);

  localparam int            PW      = cnt_width(BLINK_HALF);
  localparam logic [PW-1:0] PS_TERM = PW'(BLINK_HALF - 1);

  logic [1:0]    sw_db;
  logic          btn_db;
  logic          btn_rise;

  mode_e         mode_q, mode_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          btn_q, btn_d;
  logic [1:0]    led_q, led_d;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sw
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (bus.switch[gi]),
      .stable (sw_db[gi])
    );
  end

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (bus.mode_btn),
    .stable (btn_db)
  );

  assign btn_rise = btn_db & ~btn_q;

  // A mode change restarts the prescaler, overriding a coincident terminal count.
  always_comb begin
    btn_d   = btn_db;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (btn_rise) begin
      mode_d  = next_mode(mode_q);
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == PS_TERM) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + PW'(1);
    end
  end

  always_comb begin
    led_d = 2'b00;
    case (mode_q)
      MODE_DIRECT: led_d = {sw_db[0] & sw_db[1], sw_db[0]};
      MODE_BLINK:  led_d = {phase_q & sw_db[0] & sw_db[1], phase_q & sw_db[0]};
      MODE_CHASE:  led_d = phase_q ? 2'b10 : 2'b01;
      MODE_OFF:    led_d = 2'b00;
      default:     led_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_DIRECT;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      btn_q   <= 1'b0;
      led_q   <= 2'b00;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      btn_q   <= btn_d;
      led_q   <= led_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.mode = mode_q;

endmodule

// File: tb/tb_led_switch_ctrl.sv
// Randomised and directed checks of led_switch_ctrl against a sample-window reference model.
module tb_led_switch_ctrl;

  localparam int D  = 4;
  localparam int BH = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  led_switch_ctrl_if bus();

  led_switch_ctrl #(.DEBOUNCE_CYCLES(D), .BLINK_HALF(BH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: inputs sampled per edge; an input's debounced level flips
  // once the D samples that have reached the second sync stage all disagree with it.
  logic [2:0] hist[$];
  logic [2:0] m_stable;
  logic       m_btn_prev;
  int         m_mode;
  int         m_t;
  logic [1:0] m_led;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < D + 2; i++) hist.push_back(3'b000);
    m_stable   = 3'b000;
    m_btn_prev = 1'b0;
    m_mode     = 0;
    m_t        = 0;
    m_led      = 2'b00;
  endtask

  task automatic model_step();
    int   ph;
    logic rise;
    logic flip;
    ph = (m_t / BH) % 2;
    case (m_mode)
      0: m_led = {m_stable[0] & m_stable[1], m_stable[0]};
      1: m_led = (ph == 1) ? {m_stable[0] & m_stable[1], m_stable[0]} : 2'b00;
      2: m_led = (ph == 1) ? 2'b10 : 2'b01;
      default: m_led = 2'b00;
    endcase
    rise       = m_stable[2] & ~m_btn_prev;
    m_btn_prev = m_stable[2];
    hist.push_front({bus.mode_btn, bus.switch});
    while (hist.size() > D + 2) void'(hist.pop_back());
    for (int b = 0; b < 3; b++) begin
      flip = 1'b1;
      for (int i = 2; i <= D + 1; i++)
        if (hist[i][b] == m_stable[b]) flip = 1'b0;
      if (flip) m_stable[b] = ~m_stable[b];
    end
    if (rise) begin
      m_mode = (m_mode + 1) % 4;
      m_t    = 0;
    end else begin
      m_t++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("led", bus.led, m_led);
    check("mode", bus.mode, m_mode);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called at posedge+1; asserts reset between edges and releases it on a later falling edge.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_led", bus.led, 0);
    check("rst_mode", bus.mode, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press();
    int prev;
    prev = m_mode;
    bus.mode_btn = 1'b1;
    run(D + 2);
    check("mode_before", bus.mode, prev);
    tick();
    check("mode_after", bus.mode, (prev + 1) % 4);
    run(13);
    check("mode_held", bus.mode, (prev + 1) % 4);
    bus.mode_btn = 1'b0;
    run(10);
  endtask

  initial begin
    bus.switch   = 2'b00;
    bus.mode_btn = 1'b0;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check("init_led", bus.led, 0);
    check("init_mode", bus.mode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(3);

    // DIRECT: latency and glitch rejection
    bus.switch = 2'b01;
    run(D + 2);
    check("dir_lat_pre", bus.led, 2'b00);
    tick();
    check("dir_lat", bus.led, 2'b01);
    bus.switch = 2'b11;
    run(10);
    check("dir_11", bus.led, 2'b11);
    bus.switch = 2'b10;
    run(2);
    bus.switch = 2'b11;
    run(10);
    check("glitch", bus.led, 2'b11);

    // Mode cycling with wrap
    for (int k = 0; k < 4; k++) press();
    check("wrap", bus.mode, 0);

    // BLINK, then CHASE, OFF, DIRECT, BLINK
    press();
    run(12);
    bus.switch = 2'b01;
    run(12);
    press();
    bus.switch = 2'b10;
    run(9);
    press();
    check("off_led", bus.led, 2'b00);
    press();
    press();

    // Button rise coinciding with prescaler terminal count in BLINK
    while ((m_t % BH) != BH - 1) tick();
    bus.mode_btn = 1'b1;
    run(D + 3);
    check("tc_mode", bus.mode, 2);
    for (int i = 0; i < BH; i++) begin
      tick();
      check("tc_chase_lo", bus.led, 2'b01);
    end
    tick();
    check("tc_chase_hi", bus.led, 2'b10);
    bus.mode_btn = 1'b0;
    run(10);

    // Asynchronous reset mid-operation, then recovery latency
    bus.switch = 2'b11;
    run(10);
    mid_reset();
    run(D + 2);
    check("rec_pre", bus.led, 2'b00);
    tick();
    check("rec_led", bus.led, 2'b11);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus.switch = 2'($urandom);
      if ($urandom_range(0, 9) == 0) bus.mode_btn = ~bus.mode_btn;
      if ($urandom_range(0, 599) == 0) mid_reset();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
